// File: rtl/tdp_ram_be_pipe_if.sv
// Bus bundle for tdp_ram_be_pipe: both access ports, status and collision flag.
// The master drives the two access ports; the slave is the RAM.
interface tdp_ram_be_pipe_if #(
  parameter int data_wd = 48,
  parameter int add_wd  = 4,
  parameter int be_wd   = 6
);
  logic               init_busy;
  logic               cs_a, rnw_a, a_valid;
  logic [be_wd-1:0]   be_a;
  logic [add_wd-1:0]  a_add;
  logic [data_wd-1:0] a_data_in, a_data_out;
  logic               cs_b, rnw_b, b_valid;
  logic [be_wd-1:0]   be_b;
  logic [add_wd-1:0]  b_add;
  logic [data_wd-1:0] b_data_in, b_data_out;
  logic               collision;

  modport master (
    output cs_a, rnw_a, be_a, a_add, a_data_in,
    output cs_b, rnw_b, be_b, b_add, b_data_in,
    input  a_data_out, a_valid, b_data_out, b_valid, collision, init_busy
  );

  modport slave (
    input  cs_a, rnw_a, be_a, a_add, a_data_in,
    input  cs_b, rnw_b, be_b, b_add, b_data_in,
    output a_data_out, a_valid, b_data_out, b_valid, collision, init_busy
  );
endinterface

// File: rtl/tdp_ram_be_pipe.sv
// True dual port RAM with byte enables, read-during-write modes, optional
// output register, same-address collision flag and a post-reset clear.
module tdp_ram_be_pipe #(
  parameter int data_wd    = 48,
  parameter int add_wd     = 4,
  parameter int byte_wd    = 8,
  parameter int rd_mode    = 0,
  parameter int out_reg    = 0,
  parameter int init_clear = 1
) (
  input  logic                clk,
  input  logic                rst,
  tdp_ram_be_pipe_if.slave    bus
);
  localparam int be_wd = data_wd / byte_wd;
  localparam int depth = 1 << add_wd;

  typedef enum logic {CLEAR, READY} state_t;

  state_t              state, state_nxt;
  logic [add_wd-1:0]   ptr, ptr_nxt;
  logic [data_wd-1:0]  mem [depth];

  logic                acc_a, acc_b, wr_a, wr_b;
  logic [data_wd-1:0]  old_a, old_b;
  logic                nv_a, nv_b;
  logic [data_wd-1:0]  nd_a, nd_b;
  logic                v1_a, v1_b;
  logic [data_wd-1:0]  d1_a, d1_b;

  function automatic logic [data_wd-1:0] merge(input logic [data_wd-1:0] old,
                                               input logic [data_wd-1:0] din,
                                               input logic [be_wd-1:0]   be);
    logic [data_wd-1:0] r;
    r = old;
    for (int i = 0; i < be_wd; i++)
      if (be[i]) r[i*byte_wd +: byte_wd] = din[i*byte_wd +: byte_wd];
    return r;
  endfunction

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= (init_clear != 0) ? CLEAR : READY;
      ptr   <= '0;
    end else begin
      state <= state_nxt;
      ptr   <= ptr_nxt;
    end
  end

  // NOTE: defaults first in always_comb so no path leaves a signal unassigned (no latch).
  always_comb begin
    state_nxt = state;
    ptr_nxt   = ptr;
    if (state == CLEAR) begin
      ptr_nxt = ptr + 1'b1;
      if (ptr == add_wd'(depth - 1)) state_nxt = READY;
    end
  end

  assign bus.init_busy = (state == CLEAR);

  assign acc_a = bus.cs_a && (state == READY);
  assign acc_b = bus.cs_b && (state == READY);
  assign wr_a  = acc_a && !bus.rnw_a;
  assign wr_b  = acc_b && !bus.rnw_b;
  assign old_a = mem[bus.a_add];
  assign old_b = mem[bus.b_add];

  // NOTE: the array has no reset; clearing is done by the sequencer, one word per cycle.
  // Port B's byte writes are issued last, so it wins on bytes both ports enable.
  always_ff @(posedge clk) begin
    if (state == CLEAR) begin
      mem[ptr] <= '0;
    end else begin
      for (int i = 0; i < be_wd; i++)
        if (wr_a && bus.be_a[i])
          mem[bus.a_add][i*byte_wd +: byte_wd] <= bus.a_data_in[i*byte_wd +: byte_wd];
      for (int i = 0; i < be_wd; i++)
        if (wr_b && bus.be_b[i])
          mem[bus.b_add][i*byte_wd +: byte_wd] <= bus.b_data_in[i*byte_wd +: byte_wd];
    end
  end

  // Read data always comes from the pre-edge array, so a reader colliding
  // with the other port's write returns the old word in every mode.
  assign nv_a = acc_a && (bus.rnw_a || rd_mode != 2);
  assign nv_b = acc_b && (bus.rnw_b || rd_mode != 2);
  assign nd_a = (bus.rnw_a || rd_mode == 0) ? old_a : merge(old_a, bus.a_data_in, bus.be_a);
  assign nd_b = (bus.rnw_b || rd_mode == 0) ? old_b : merge(old_b, bus.b_data_in, bus.be_b);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      v1_a          <= 1'b0;
      v1_b          <= 1'b0;
      d1_a          <= '0;
      d1_b          <= '0;
      bus.collision <= 1'b0;
    end else begin
      v1_a          <= nv_a;
      v1_b          <= nv_b;
      if (nv_a) d1_a <= nd_a;
      if (nv_b) d1_b <= nd_b;
      bus.collision <= acc_a && acc_b && (bus.a_add == bus.b_add) && (wr_a || wr_b);
    end
  end

  generate
    if (out_reg != 0) begin : g_pipe
      logic               v2_a, v2_b;
      logic [data_wd-1:0] d2_a, d2_b;
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          v2_a <= 1'b0;
          v2_b <= 1'b0;
          d2_a <= '0;
          d2_b <= '0;
        end else begin
          v2_a <= v1_a;
          v2_b <= v1_b;
          if (v1_a) d2_a <= d1_a;
          if (v1_b) d2_b <= d1_b;
        end
      end
      assign bus.a_valid    = v2_a;
      assign bus.b_valid    = v2_b;
      assign bus.a_data_out = d2_a;
      assign bus.b_data_out = d2_b;
    end else begin : g_direct
      assign bus.a_valid    = v1_a;
      assign bus.b_valid    = v1_b;
      assign bus.a_data_out = d1_a;
      assign bus.b_data_out = d1_b;
    end
  endgenerate
endmodule
